// File: rtl/apb_rd_cmd_sequencer.sv
// APB-domain command sequencer for the AHB2APB bridge.
// Pops command words, runs APB transfers, returns read responses.
module apb_rd_cmd_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_W   = 8
) (
  input  logic                     r_clk,
  input  logic                     r_rstn,
  input  logic                     cmd_empty,
  input  logic [ADDR_W+DATA_W:0]   cmd_rdata,
  output logic                     cmd_r_inc,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  output logic                     pwrite,
  output logic                     psel,
  output logic                     penable,
  input  logic                     pready,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pslverr,
  input  logic                     rsp_full,
  output logic                     rsp_w_inc,
  output logic [DATA_W:0]          rsp_wdata,
  output logic                     wr_err,
  input  logic                     wr_err_clr,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  // Last count value before the limit; reaching the limit aborts.
  localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            wr_err_set;

  assign to_hit = (to_cnt == TO_LAST);

  assign wr_err_set = (state == ACCESS) && pwrite &&
                      ((pready && pslverr) || (!pready && to_hit));

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      state     <= IDLE;
      to_cnt    <= '0;
      cmd_r_inc <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_w_inc <= 1'b0;
      rsp_wdata <= '0;
      wr_err    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_r_inc <= 1'b0;
      rsp_w_inc <= 1'b0;
      wr_err    <= wr_err_set | (wr_err & ~wr_err_clr);
      unique case (state)
        IDLE: begin
          if (!cmd_empty) begin
            cmd_r_inc <= 1'b1;
            {pwrite, paddr, pwdata} <= cmd_rdata;
            psel  <= 1'b1;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          to_cnt  <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready || to_hit) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pwrite) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              rsp_wdata <= pready ? {pslverr, prdata}
                                  : {1'b1, {DATA_W{1'b0}}};
              // Push on RESP entry when the FIFO already has room.
              rsp_w_inc <= !rsp_full;
              state     <= RESP;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_w_inc) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!rsp_full) begin
            rsp_w_inc <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rd_cmd_sequencer.sv
// Scoreboard bench for apb_rd_cmd_sequencer.
// Models the command FIFO, APB slave and response FIFO.
module tb_apb_rd_cmd_sequencer;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int TMO = (1 << TW) - 1;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            waits;
  } txn_t;

  logic          r_clk = 1'b0;
  logic          r_rstn = 1'b0;
  logic          cmd_empty = 1'b1;
  logic [AW+DW:0] cmd_rdata = '0;
  logic          cmd_r_inc;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite, psel, penable;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;
  logic          rsp_full = 1'b0;
  logic          rsp_w_inc;
  logic [DW:0]   rsp_wdata;
  logic          wr_err;
  logic          wr_err_clr = 1'b0;
  logic          busy;

  apb_rd_cmd_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TO_W(TW)) dut (
    .r_clk(r_clk), .r_rstn(r_rstn),
    .cmd_empty(cmd_empty), .cmd_rdata(cmd_rdata), .cmd_r_inc(cmd_r_inc),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .pready(pready),
    .prdata(prdata), .pslverr(pslverr),
    .rsp_full(rsp_full), .rsp_w_inc(rsp_w_inc), .rsp_wdata(rsp_wdata),
    .wr_err(wr_err), .wr_err_clr(wr_err_clr), .busy(busy)
  );

  always #5 r_clk = ~r_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge r_clk) cyc <= cyc + 1;

  logic full_at_edge = 1'b0;
  always @(posedge r_clk) full_at_edge <= rsp_full;

  txn_t           cmd_q[$];
  logic [AW+DW:0] exp_apb[$];
  logic [DW:0]    exp_rsp[$];
  int             pop_cyc[$];

  int n_pop, n_psel, n_pen, n_busy, n_rsp, rsp_cyc, done_rd_cyc;
  bit rnd_full = 0, rnd_clr = 0, force_clr = 0, clr_on_done = 0;
  int full_arm = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(logic wr, logic [AW-1:0] a, logic [DW-1:0] wd,
                              logic [DW-1:0] rd, logic e, int w);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd;
    t.rdata = rd; t.err = e; t.waits = w;
    return t;
  endfunction

  // Expected results are fixed at issue time from the transfer rules.
  task automatic issue(txn_t t);
    cmd_q.push_back(t);
    exp_apb.push_back({t.wr, t.addr, t.wdata});
    if (!t.wr) begin
      if (t.waits >= TMO) exp_rsp.push_back({1'b1, {DW{1'b0}}});
      else                exp_rsp.push_back({t.err, t.rdata});
    end
  endtask

  task automatic clr_cnt();
    n_pop = 0; n_psel = 0; n_pen = 0; n_busy = 0; n_rsp = 0;
    rsp_cyc = -1; done_rd_cyc = -100;
    pop_cyc.delete();
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    do begin
      @(posedge r_clk); #1;
      n++;
    end while (!(cmd_q.size() == 0 && !busy && !cmd_r_inc) && n < lim);
    @(negedge r_clk);
    chk("drain_in_time", n < lim, 1);
  endtask

  // Command FIFO, APB slave, response FIFO and wr_err model.
  initial begin
    txn_t cur;
    int   acc;
    logic exp_wr;
    int   full_hold;
    bit   done, tmo, clr;
    cur = mk(0, 0, 0, 0, 0, 0);
    acc = 0; exp_wr = 0; full_hold = 0;
    forever begin
      @(negedge r_clk);
      if (!r_rstn) begin
        pready = 0; rsp_full = 0; wr_err_clr = 0;
        exp_wr = 0; acc = 0; full_hold = 0;
      end else begin
        chk("wr_err", wr_err, exp_wr);
        if (cmd_r_inc) begin
          chk("pop_nonempty", cmd_q.size() != 0, 1);
          if (cmd_q.size() != 0) cur = cmd_q.pop_front();
          acc = 0;
        end
        done = 0; tmo = 0; pready = 0;
        prdata = $urandom; pslverr = 1'($urandom_range(1));
        if (psel && penable) begin
          if (acc == cur.waits) begin
            pready = 1; prdata = cur.rdata; pslverr = cur.err; done = 1;
          end else if (acc == TMO - 1) begin
            done = 1; tmo = 1;
          end
          acc++;
        end
        if (done && !cur.wr) done_rd_cyc = cyc;
        clr = force_clr || (done && clr_on_done) ||
              (rnd_clr && $urandom_range(9) == 0);
        force_clr = 0;
        wr_err_clr = clr;
        if (done && cur.wr && (tmo || cur.err)) exp_wr = 1;
        else if (clr) exp_wr = 0;
        if (done && !cur.wr && full_arm > 0) begin
          full_hold = full_arm; full_arm = 0;
        end
        if (full_hold > 0) begin
          rsp_full = 1; full_hold--;
        end else begin
          rsp_full = rnd_full && ($urandom_range(3) == 0);
        end
      end
      cmd_empty = (cmd_q.size() == 0);
      cmd_rdata = cmd_empty ? '0 : {cmd_q[0].wr, cmd_q[0].addr, cmd_q[0].wdata};
    end
  end

  // Monitor: APB address phase and response pushes against scoreboard.
  initial begin
    logic [AW+DW:0] cur_apb = '0;
    forever begin
      @(negedge r_clk);
      if (r_rstn) begin
        if (psel && !penable) begin
          chk("apb_expected", exp_apb.size() != 0, 1);
          if (exp_apb.size() != 0) begin
            cur_apb = exp_apb.pop_front();
            chk("apb_setup", {pwrite, paddr, pwdata}, cur_apb);
          end
        end
        if (psel && penable) chk("apb_hold", {pwrite, paddr, pwdata}, cur_apb);
        if (penable) chk("penable_with_psel", psel, 1);
        if (psel) n_psel++;
        if (penable) n_pen++;
        if (busy) n_busy++;
        if (cmd_r_inc) begin
          n_pop++;
          pop_cyc.push_back(cyc);
        end
        if (rsp_w_inc) begin
          n_rsp++;
          rsp_cyc = cyc;
          chk("rsp_not_full", full_at_edge, 0);
          chk("rsp_expected", exp_rsp.size() != 0, 1);
          if (exp_rsp.size() != 0) chk("rsp_word", rsp_wdata, exp_rsp.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    txn_t t;
    clr_cnt();
    #12;
    chk("reset_ctl", {cmd_r_inc, psel, penable, pwrite, rsp_w_inc, wr_err, busy}, 0);
    chk("reset_addr_data", {paddr, pwdata}, 0);
    chk("reset_rsp", rsp_wdata, 0);
    r_rstn = 1;
    repeat (2) @(posedge r_clk); #1;

    // single write
    clr_cnt();
    issue(mk(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0));
    wait_idle(50);
    chk("wr_pops", n_pop, 1);
    chk("wr_psel_cycles", n_psel, 2);
    chk("wr_pen_cycles", n_pen, 1);
    chk("wr_no_rsp", n_rsp, 0);
    chk("wr_busy_cycles", n_busy, 2);

    // read with 3 wait states
    clr_cnt();
    issue(mk(0, 32'h44, 32'h0, 32'h1234_5678, 0, 3));
    wait_idle(50);
    chk("rd_pen_cycles", n_pen, 4);
    chk("rd_rsp_count", n_rsp, 1);
    chk("rd_rsp_latency", rsp_cyc - done_rd_cyc, 1);

    // read completing into a full response FIFO, write queued behind
    clr_cnt();
    full_arm = 5;
    issue(mk(0, 32'h80, 32'h0, 32'hCAFE_0001, 1, 0));
    issue(mk(1, 32'h84, 32'h5555_AAAA, 0, 0, 0));
    wait_idle(80);
    chk("full_rsp_latency", rsp_cyc - done_rd_cyc, 6);
    chk("full_pops", n_pop, 2);
    if (pop_cyc.size() == 2) chk("full_no_early_pop", pop_cyc[1] - rsp_cyc, 2);

    // back-to-back writes
    clr_cnt();
    for (int i = 0; i < 3; i++) issue(mk(1, 32'h100 + i * 4, 32'hA0 + i, 0, 0, 0));
    wait_idle(80);
    chk("b2b_pops", n_pop, 3);
    chk("b2b_psel_cycles", n_psel, 6);
    if (pop_cyc.size() == 3) begin
      chk("b2b_spacing0", pop_cyc[1] - pop_cyc[0], 3);
      chk("b2b_spacing1", pop_cyc[2] - pop_cyc[1], 3);
    end

    // sticky write error, clear, set-beats-clear
    issue(mk(1, 32'h20, 32'h1, 0, 1, 1));
    wait_idle(50);
    chk("wr_err_set", wr_err, 1);
    repeat (3) @(posedge r_clk); #1;
    chk("wr_err_sticky", wr_err, 1);
    force_clr = 1;
    repeat (2) @(posedge r_clk); #1;
    chk("wr_err_cleared", wr_err, 0);
    clr_on_done = 1;
    issue(mk(1, 32'h24, 32'h2, 0, 1, 0));
    wait_idle(50);
    clr_on_done = 0;
    chk("wr_err_set_wins", wr_err, 1);

    // read timeout
    clr_cnt();
    issue(mk(0, 32'h200, 32'h0, 32'hFFFF_FFFF, 0, 99));
    wait_idle(80);
    chk("tmo_access_cycles", n_pen, TMO);
    chk("tmo_rsp_count", n_rsp, 1);

    // reset during SETUP
    @(posedge r_clk); #1;
    issue(mk(1, 32'h300, 32'h3, 0, 0, 0));
    n = 0;
    do begin
      @(posedge r_clk); #1;
      n++;
    end while (!(psel && !penable) && n < 20);
    chk("setup_reached", psel && !penable, 1);
    r_rstn = 0;
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_r_inc", cmd_r_inc, 0);
    cmd_q.delete(); exp_apb.delete(); exp_rsp.delete();
    repeat (2) @(posedge r_clk); #2;
    r_rstn = 1;
    repeat (2) @(posedge r_clk); #1;
    chk("rst_stays_idle", {busy, psel, cmd_r_inc}, 0);

    // randomized traffic
    rnd_full = 1; rnd_clr = 1;
    for (int i = 0; i < 150; i++) begin
      t.wr = 1'($urandom_range(1));
      t.addr = $urandom; t.wdata = $urandom; t.rdata = $urandom;
      t.err = ($urandom_range(3) == 0);
      case ($urandom_range(9))
        0: t.waits = TMO - 1;
        1: t.waits = TMO + $urandom_range(5);
        default: t.waits = $urandom_range(3);
      endcase
      issue(t);
      repeat (1 + $urandom_range(3)) @(posedge r_clk);
      #1;
    end
    wait_idle(5000);
    rnd_full = 0; rnd_clr = 0;
    chk("rand_apb_drained", exp_apb.size(), 0);
    chk("rand_rsp_drained", exp_rsp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_rd_cmd_sequencer.md
Name: apb_rd_cmd_sequencer

Overview:
- Read-domain (APB clock) controller of the AHB2APB bridge.
- Pops command words from the async command FIFO read port, one at a time, and runs each as an APB transfer.
- Read results (data + error) are pushed into the response FIFO toward the AHB domain.
- Also provides a per-transfer PREADY timeout and sticky write-error reporting.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TO_W, 8, timeout counter width. Timeout limit is 2^TO_W-1 ACCESS cycles.

Ports:
- r_clk  in  1  read-domain clock.
- r_rstn  in  1  read-domain reset.
- cmd_empty  in  1  command FIFO empty flag.
- cmd_rdata  in  1+ADDR_W+DATA_W  command word at current FIFO read address (async read). Layout: [MSB]=write, then addr, then wdata in the LSBs.
- cmd_r_inc  out  1  command FIFO pop strobe.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pready  in  1  APB ready.
- prdata  in  DATA_W  APB read data.
- pslverr  in  1  APB slave error.
- rsp_full  in  1  response FIFO full flag.
- rsp_w_inc  out  1  response FIFO push strobe.
- rsp_wdata  out  DATA_W+1  response word: {err, rdata}.
- wr_err  out  1  sticky flag: a write ended in error.
- wr_err_clr  in  1  clears wr_err.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: r_rstn is asynchronous, active-low; clock is r_clk. All outputs reset to 0, the command register to 0, the timeout counter to 0, and the FSM to IDLE. All outputs are driven from registers.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If !cmd_empty, assert cmd_r_inc for exactly one cycle.
  - Capture cmd_rdata into {pwrite, paddr, pwdata} on the same edge, then go to SETUP.
  - cmd_r_inc is never asserted when cmd_empty=1.
- SETUP: psel=1, penable=0, for one cycle; clear the timeout counter; go to ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwdata and pwrite are held stable.
  - pready=1, read: capture {pslverr, prdata} into rsp_wdata and go to RESP.
  - pready=1, write: if pslverr=1, set wr_err; go to IDLE.
  - pready=0: increment the timeout counter. When the counter reaches 2^TO_W-1 with pready still 0, abort the transfer:
    - read: rsp_wdata = {1, all zeros}, go to RESP.
    - write: set wr_err, go to IDLE.
  - psel and penable drop to 0 on leaving ACCESS.
- RESP:
  - If !rsp_full, assert rsp_w_inc for one cycle and go to IDLE.
  - Else hold rsp_wdata and wait. No new command is popped while in RESP.
- Throughput (no wait states):
  - Write: 3 cycles per command (IDLE pop, SETUP, ACCESS).
  - Read: 4 cycles per command (adds RESP).
  - psel is deasserted for at least the IDLE cycle between transfers.
- wr_err:
  - Set has priority over wr_err_clr in the same cycle.
  - Otherwise wr_err_clr=1 clears it.
- busy = (state != IDLE).
- Reset mid-transfer: everything returns to reset values immediately. The in-flight command is lost and not re-popped. The FIFO's own reset handles pointer recovery.
- No combinational path from inputs to outputs.

Test Plan:
- Single write, cmd {1, 0x0000_0010, 0xDEAD_BEEF}, pready=1 in the first ACCESS cycle:
  - cmd_r_inc pulses for 1 cycle; psel high 2 cycles, penable high 1 cycle; paddr=0x10, pwdata=0xDEADBEEF.
  - No rsp_w_inc; busy high 2 cycles.
- Read with 3 wait states, prdata=0x1234_5678, pslverr=0 -> rsp_wdata=0x0_1234_5678, rsp_w_inc pulses once, 1 cycle after pready.
- Read completes while rsp_full=1 for 5 cycles -> FSM holds in RESP, no cmd_r_inc, rsp_w_inc pulses on the first cycle with rsp_full=0.
- Back-to-back: 3 writes queued (cmd_empty=0 for 3 pops) -> cmd_r_inc pulses exactly 3 times at 3-cycle spacing; psel low for 1 cycle between transfers.
- Write with pslverr=1 -> wr_err=1 and sticky. A wr_err_clr pulse clears it. A simultaneous new error plus wr_err_clr keeps wr_err=1.
- Timeout, TO_W=4, pready held 0 on a read -> abort after 15 ACCESS cycles, rsp_wdata={1, 0}. Then r_rstn asserted during a following SETUP -> psel=0 and busy=0 immediately.
